lane_mem_serializer: RTL

- Memory-stage block directly downstream of the 6-lane vector ALU.
- Takes a 6-lane vector result, or a lane-packed store value, plus a base address from the EX/MEM register.
- Moves the vector to or from the byte-wide (N-bit) data memory one lane per cycle.
- Stalls the pipeline while busy and returns assembled load data for writeback.

---
 rtl/lane_mem_serializer_if.sv | 53 +++++
 rtl/lane_mem_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lane_mem_serializer_if.sv
// Bus bundle between the EX/MEM pipeline stage, the lane serializer and the
// byte-wide data memory. slave is the serializer's view; master is the environment's.
interface lane_mem_serializer_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned LANES = 6,
    parameter int unsigned AW    = 16
);
    // pipeline request side
    logic                        StartM;
    logic                        MemWriteM;
    logic [AW-1:0]               AddrM;
    logic [LANES-1:0][N-1:0]     WriteDataM;
    logic [LANES-1:0][N-1:0]     ReadDataM;
    logic                        BusyM;
    logic                        DoneM;

    // data memory side
    logic [AW-1:0]               MemAddr;
    logic                        MemWE;
    logic                        MemRE;
    logic [N-1:0]                MemWData;
    logic [N-1:0]                MemRData;

    modport slave (
        input  StartM,
        input  MemWriteM,
        input  AddrM,
        input  WriteDataM,
        input  MemRData,
        output ReadDataM,
        output BusyM,
        output DoneM,
        output MemAddr,
        output MemWE,
        output MemRE,
        output MemWData
    );

    modport master (
        output StartM,
        output MemWriteM,
        output AddrM,
        output WriteDataM,
        output MemRData,
        input  ReadDataM,
        input  BusyM,
        input  DoneM,
        input  MemAddr,
        input  MemWE,
        input  MemRE,
        input  MemWData
    );
endinterface

// File: rtl/lane_mem_serializer.sv
// Moves a LANES-wide vector to/from an N-bit synchronous-read data memory one
// lane per cycle, stalling the pipeline while busy and assembling load results.
module lane_mem_serializer #(
    parameter int unsigned N     = 8,
    parameter int unsigned LANES = 6,
    parameter int unsigned AW    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    lane_mem_serializer_if.slave   bus
);

    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state,    state_n;
    logic [AW-1:0]            base,     base_n;
    logic [LANES-1:0][N-1:0]  lane_buf, lane_buf_n;
    logic [IW-1:0]            idx,      idx_n;
    logic [IW-1:0]            cidx,     cidx_n;
    logic [IW-1:0]            idx_nxt;

    logic [LANES-1:0][N-1:0]  rdata,    rdata_n;
    logic [AW-1:0]            addr,     addr_n;
    logic                     we,       we_n;
    logic                     re,       re_n;
    logic [N-1:0]             wdata,    wdata_n;
    logic                     busy,     busy_n;
    logic                     done,     done_n;

    assign idx_nxt = idx + IW'(1);

    // Next state plus the memory/pipeline outputs for the cycle that follows,
    // so every output can be a flop yet still line up with its access cycle.
    always_comb begin
        state_n    = state;
        base_n     = base;
        lane_buf_n = lane_buf;
        idx_n      = idx;
        cidx_n     = cidx;
        rdata_n    = rdata;
        addr_n     = '0;
        we_n       = 1'b0;
        re_n       = 1'b0;
        wdata_n    = '0;

        case (state)
            IDLE: begin
                if (bus.StartM) begin
                    base_n     = bus.AddrM;
                    lane_buf_n = bus.WriteDataM;
                    idx_n      = '0;
                    cidx_n     = '0;
                    addr_n     = bus.AddrM;
                    if (bus.MemWriteM) begin
                        state_n = WR;
                        we_n    = 1'b1;
                        wdata_n = bus.WriteDataM[0];
                    end else begin
                        state_n = RD;
                        re_n    = 1'b1;
                    end
                end
            end

            WR: begin
                if (idx == LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx_nxt;
                    we_n    = 1'b1;
                    addr_n  = base + AW'(idx_nxt);
                    wdata_n = lane_buf[idx_nxt];
                end
            end

            RD: begin
                // read data trails its issue by one cycle
                if (idx != '0) begin
                    rdata_n[cidx] = bus.MemRData;
                    cidx_n        = cidx + IW'(1);
                end
                if (idx == LAST) begin
                    state_n = DRAIN;
                end else begin
                    idx_n  = idx_nxt;
                    re_n   = 1'b1;
                    addr_n = base + AW'(idx_nxt);
                end
            end

            DRAIN: begin
                rdata_n[cidx] = bus.MemRData;
                state_n       = DONE;
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == WR) || (state_n == RD) || (state_n == DRAIN);
        done_n = (state_n == DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            lane_buf <= '0;
            idx      <= '0;
            cidx     <= '0;
        end else begin
            state    <= state_n;
            base     <= base_n;
            lane_buf <= lane_buf_n;
            idx      <= idx_n;
            cidx     <= cidx_n;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
            addr  <= '0;
            we    <= 1'b0;
            re    <= 1'b0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            rdata <= rdata_n;
            addr  <= addr_n;
            we    <= we_n;
            re    <= re_n;
            wdata <= wdata_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    assign bus.ReadDataM = rdata;
    assign bus.MemAddr   = addr;
    assign bus.MemWE     = we;
    assign bus.MemRE     = re;
    assign bus.MemWData  = wdata;
    assign bus.BusyM     = busy;
    assign bus.DoneM     = done;

endmodule
